// File: rtl/timer_pkg.sv
// Register map, TCR/TSR bit positions and controller states shared by the
// timer reload controller and its sub-blocks.
package timer_pkg;

    localparam logic [7:0] TDR_ADDR = 8'h00;
    localparam logic [7:0] TCR_ADDR = 8'h01;
    localparam logic [7:0] TSR_ADDR = 8'h02;

    localparam int TCR_LOAD_BIT = 7;
    localparam int TCR_DOWN_BIT = 5;
    localparam int TCR_EN_BIT   = 4;

    localparam int TSR_UNF_BIT = 1;
    localparam int TSR_OVF_BIT = 0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_TDR,
        ST_WR_LOAD,
        ST_WR_RUN,
        ST_RUN,
        ST_RD_TSR,
        ST_CLR_TSR,
        ST_WR_PAUSE,
        ST_ERROR
    } state_t;

    function automatic logic [7:0] tcr_word(input logic load, input logic en,
                                            input logic down, input logic [1:0] cks);
        logic [7:0] w;
        w = 8'h00;
        w[TCR_LOAD_BIT] = load;
        w[TCR_EN_BIT]   = en;
        w[TCR_DOWN_BIT] = down;
        w[1:0]          = cks;
        return w;
    endfunction

endpackage

// File: rtl/apb_master_xfer.sv
// Single APB transfer engine: one SETUP + ACCESS transfer per i_req pulse,
// reports done/fail, with a bounded wait for pready.
module apb_master_xfer #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              i_req,
    input  logic              i_wr,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_done,
    output logic              o_fail,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_psel,
    output logic              o_penable,
    output logic              o_pwrite,
    output logic [ADDR_W-1:0] o_paddr,
    output logic [DATA_W-1:0] o_pwdata,
    input  logic [DATA_W-1:0] i_prdata,
    input  logic              i_pready,
    input  logic              i_pslverr
);

    typedef enum logic [1:0] {X_IDLE, X_SETUP, X_ACCESS} xfer_state_t;

    localparam int          TW    = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    xfer_state_t       r_state;
    xfer_state_t       w_state_next;
    logic [TW-1:0]     r_wait;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              w_access;
    logic              w_timeout;

    assign w_access  = (r_state == X_ACCESS);
    assign w_timeout = w_access && !i_pready && (r_wait == TLAST);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            X_IDLE:   if (i_req) w_state_next = X_SETUP;
            X_SETUP:  w_state_next = X_ACCESS;
            X_ACCESS: if (i_pready || w_timeout) w_state_next = X_IDLE;
            default:  w_state_next = X_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= X_IDLE;
            r_wait  <= '0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == X_IDLE && i_req) begin
                r_wr    <= i_wr;
                r_addr  <= i_addr;
                r_wdata <= i_wdata;
            end
            // r_wait counts ACCESS cycles spent without pready
            if (w_access && !i_pready) r_wait <= r_wait + 1'b1;
            else                       r_wait <= '0;
        end
    end

    assign o_done = w_access && i_pready && !i_pslverr;
    assign o_fail = (w_access && i_pready && i_pslverr) || w_timeout;
    assign o_rdata = i_prdata;

    // Bus is driven to all-zero whenever no transfer is in progress
    assign o_psel    = (r_state != X_IDLE);
    assign o_penable = w_access;
    assign o_pwrite  = o_psel & r_wr;
    assign o_paddr   = o_psel ? r_addr  : '0;
    assign o_pwdata  = o_psel ? r_wdata : '0;

endmodule

// File: rtl/timer_reload_ctrl.sv
// Autonomous APB master that programs the 8-bit timer, services its
// period interrupts and emits one tick per serviced period.
module timer_reload_ctrl
    import timer_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              start,
    input  logic              stop,
    input  logic              auto_reload,
    input  logic [DATA_W-1:0] reload_val,
    input  logic              cfg_down,
    input  logic [1:0]        cfg_cks,
    input  logic              err_clr,
    input  logic              irq_in,
    output logic              m_psel,
    output logic              m_penable,
    output logic              m_pwrite,
    output logic [ADDR_W-1:0] m_paddr,
    output logic [DATA_W-1:0] m_pwdata,
    input  logic [DATA_W-1:0] m_prdata,
    input  logic              m_pready,
    input  logic              m_pslverr,
    output logic              busy,
    output logic              tick,
    output logic [CNT_W-1:0]  period_cnt,
    output logic              err
);

    state_t            r_state;
    state_t            w_state_next;
    logic              r_inflight;
    logic              r_stop_pend;
    logic              r_down;
    logic              r_auto;
    logic [1:0]        r_cks;
    logic [DATA_W-1:0] r_reload;
    logic              r_tick;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;

    logic              w_xfer_state;
    logic              w_req;
    logic              w_wr;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_done;
    logic              w_fail;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] w_flag_mask;
    logic              w_flag;
    logic              w_stop_any;
    logic              w_enter_tdr;
    logic              w_period_done;

    assign w_xfer_state = (r_state inside {ST_WR_TDR, ST_WR_LOAD, ST_WR_RUN,
                                           ST_RD_TSR, ST_CLR_TSR, ST_WR_PAUSE});
    assign w_req        = w_xfer_state && !r_inflight;
    assign w_stop_any   = stop || r_stop_pend;
    assign w_flag_mask  = r_down ? DATA_W'(1 << TSR_UNF_BIT) : DATA_W'(1 << TSR_OVF_BIT);
    assign w_flag       = |(w_rdata & w_flag_mask);
    assign w_enter_tdr  = (w_state_next == ST_WR_TDR) && (r_state != ST_WR_TDR);
    assign w_period_done = (r_state == ST_CLR_TSR) && w_done;

    always_comb begin
        w_wr    = 1'b1;
        w_addr  = '0;
        w_wdata = '0;
        case (r_state)
            ST_WR_TDR: begin
                w_addr  = ADDR_W'(TDR_ADDR);
                w_wdata = r_reload;
            end
            ST_WR_LOAD: begin
                w_addr  = ADDR_W'(TCR_ADDR);
                w_wdata = DATA_W'(tcr_word(1'b1, 1'b0, r_down, r_cks));
            end
            ST_WR_RUN: begin
                w_addr  = ADDR_W'(TCR_ADDR);
                w_wdata = DATA_W'(tcr_word(1'b0, 1'b1, r_down, r_cks));
            end
            ST_RD_TSR: begin
                w_wr   = 1'b0;
                w_addr = ADDR_W'(TSR_ADDR);
            end
            ST_CLR_TSR: begin
                w_addr = ADDR_W'(TSR_ADDR);
            end
            ST_WR_PAUSE: begin
                w_addr  = ADDR_W'(TCR_ADDR);
                w_wdata = DATA_W'(tcr_word(1'b0, 1'b0, r_down, r_cks));
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start && !stop) w_state_next = ST_WR_TDR;
            ST_RUN: begin
                if (stop)        w_state_next = ST_WR_PAUSE;
                else if (irq_in) w_state_next = ST_RD_TSR;
            end
            ST_ERROR: if (err_clr) w_state_next = ST_IDLE;
            default: begin
                // A pending stop redirects at the end of whichever transfer is running
                if (w_fail) begin
                    w_state_next = ST_ERROR;
                end else if (w_done) begin
                    if (r_state == ST_WR_PAUSE) begin
                        w_state_next = ST_IDLE;
                    end else if (w_stop_any) begin
                        w_state_next = ST_WR_PAUSE;
                    end else begin
                        case (r_state)
                            ST_WR_TDR:  w_state_next = ST_WR_LOAD;
                            ST_WR_LOAD: w_state_next = ST_WR_RUN;
                            ST_WR_RUN:  w_state_next = ST_RUN;
                            ST_RD_TSR:  w_state_next = w_flag ? ST_CLR_TSR : ST_RUN;
                            ST_CLR_TSR: w_state_next = r_auto ? ST_WR_TDR : ST_RUN;
                            default:    w_state_next = ST_IDLE;
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state     <= ST_IDLE;
            r_inflight  <= 1'b0;
            r_stop_pend <= 1'b0;
            r_down      <= 1'b0;
            r_auto      <= 1'b0;
            r_cks       <= 2'b00;
            r_reload    <= '0;
            r_tick      <= 1'b0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_done || w_fail) r_inflight <= 1'b0;
            else if (w_req)       r_inflight <= 1'b1;
            if (w_state_next inside {ST_IDLE, ST_WR_PAUSE, ST_ERROR}) r_stop_pend <= 1'b0;
            else if (stop && w_xfer_state)                            r_stop_pend <= 1'b1;
            if (r_state == ST_IDLE && w_state_next == ST_WR_TDR) r_down <= cfg_down;
            if (w_enter_tdr) begin
                r_reload <= reload_val;
                r_auto   <= auto_reload;
                r_cks    <= cfg_cks;
            end
            r_tick <= w_period_done;
            if (w_period_done) r_cnt <= r_cnt + 1'b1;
            r_err <= (w_state_next == ST_ERROR);
        end
    end

    apb_master_xfer #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) u_xfer (
        .pclk      (pclk),
        .presetn   (presetn),
        .i_req     (w_req),
        .i_wr      (w_wr),
        .i_addr    (w_addr),
        .i_wdata   (w_wdata),
        .o_done    (w_done),
        .o_fail    (w_fail),
        .o_rdata   (w_rdata),
        .o_psel    (m_psel),
        .o_penable (m_penable),
        .o_pwrite  (m_pwrite),
        .o_paddr   (m_paddr),
        .o_pwdata  (m_pwdata),
        .i_prdata  (m_prdata),
        .i_pready  (m_pready),
        .i_pslverr (m_pslverr)
    );

    assign busy       = !(r_state == ST_IDLE || r_state == ST_ERROR);
    assign tick       = r_tick;
    assign period_cnt = r_cnt;
    assign err        = r_err;

endmodule

// File: tb/tb_timer_reload_ctrl.sv
// Directed bench: vector table of control actions vs expected APB traffic,
// plus sequences for timeout, slave error, pending stop, reset and wrap.
module tb_timer_reload_ctrl;

    localparam int CW = 3;
    localparam int A_NONE = 0, A_START = 1, A_IRQ = 2, A_STOP = 3, A_SS = 4, A_IRQ_STOP = 5;

    logic          pclk = 1'b0;
    logic          presetn = 1'b0;
    logic          start = 0, stop = 0, auto_reload = 0, cfg_down = 0, err_clr = 0, irq_in = 0;
    logic [7:0]    reload_val = 0;
    logic [1:0]    cfg_cks = 0;
    logic          m_psel, m_penable, m_pwrite;
    logic [7:0]    m_paddr, m_pwdata;
    logic [7:0]    m_prdata = 0;
    logic          m_pready = 0, m_pslverr = 0;
    logic          busy, tick, err;
    logic [CW-1:0] period_cnt;

    int checks = 0;
    int errors = 0;

    // slave model controls and observations
    int          slv_wait = 0;
    bit          slv_hang = 0;
    int          slv_err_idx = -1;
    int          xfer_idx = 0;
    int          acc_cnt = 0;
    int          last_acc = 0;
    int          tick_cnt = 0;
    logic [7:0]  tsr_val = 0;
    logic [16:0] log_q[$];

    timer_reload_ctrl #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(16), .CNT_W(CW)) dut (
        .pclk(pclk), .presetn(presetn), .start(start), .stop(stop),
        .auto_reload(auto_reload), .reload_val(reload_val), .cfg_down(cfg_down),
        .cfg_cks(cfg_cks), .err_clr(err_clr), .irq_in(irq_in),
        .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_prdata(m_prdata),
        .m_pready(m_pready), .m_pslverr(m_pslverr),
        .busy(busy), .tick(tick), .period_cnt(period_cnt), .err(err)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [16:0] xw(input logic [7:0] a, input logic [7:0] d);
        return {1'b1, a, d};
    endfunction

    function automatic logic [16:0] xr(input logic [7:0] a, input logic [7:0] d);
        return {1'b0, a, d};
    endfunction

    // APB slave: responds at the negedge, logs completed transfers, checks phase ordering
    initial begin
        logic       p_psel, p_pen, p_pwr;
        logic [7:0] p_addr, p_wdata;
        p_psel = 0; p_pen = 0; p_pwr = 0; p_addr = 0; p_wdata = 0;
        forever begin
            @(negedge pclk);
            if (m_psel && m_penable) begin
                acc_cnt++;
                if (acc_cnt == 1)
                    check("apb setup->access", {p_psel, p_pen, p_pwr, p_addr, p_wdata},
                          {1'b1, 1'b0, m_pwrite, m_paddr, m_pwdata});
                if (!slv_hang && acc_cnt > slv_wait) begin
                    m_pready  = 1'b1;
                    m_pslverr = (xfer_idx == slv_err_idx);
                    m_prdata  = (!m_pwrite && m_paddr == 8'h02) ? tsr_val : 8'h00;
                    log_q.push_back({m_pwrite, m_paddr, m_pwrite ? m_pwdata : m_prdata});
                    xfer_idx++;
                end else begin
                    m_pready = 1'b0; m_pslverr = 1'b0;
                end
            end else begin
                if (acc_cnt != 0) last_acc = acc_cnt;
                acc_cnt = 0;
                m_pready = 1'b0; m_pslverr = 1'b0; m_prdata = 8'h00;
                if (!m_psel)
                    check("apb idle bus", {m_penable, m_pwrite, m_paddr, m_pwdata}, 0);
            end
            p_psel = m_psel; p_pen = m_penable; p_pwr = m_pwrite;
            p_addr = m_paddr; p_wdata = m_pwdata;
        end
    end

    initial begin
        forever begin
            @(negedge pclk);
            if (tick === 1'b1) tick_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    task automatic pulse(input int act);
        @(negedge pclk);
        start  = (act == A_START || act == A_SS);
        stop   = (act == A_STOP || act == A_SS || act == A_IRQ_STOP);
        irq_in = (act == A_IRQ || act == A_IRQ_STOP);
        @(negedge pclk);
        start = 0; stop = 0; irq_in = 0;
    endtask

    task automatic pulse_clr();
        @(negedge pclk);
        err_clr = 1;
        @(negedge pclk);
        err_clr = 0;
    endtask

    typedef struct {
        string           name;
        int              act;
        logic [7:0]      rv;
        logic            down;
        logic [1:0]      cks;
        logic            auto_r;
        logic [7:0]      tsr;
        int              n;
        logic [4:0][16:0] xs;
        int              ticks;
        int              cnt;
        logic            busy;
    } vec_t;

    function automatic vec_t mk(input string nm, input int act, input logic [7:0] rv,
                                input logic dn, input logic [1:0] ck, input logic au,
                                input logic [7:0] ts, input int n,
                                input logic [16:0] x0, input logic [16:0] x1,
                                input logic [16:0] x2, input logic [16:0] x3,
                                input logic [16:0] x4, input int tk, input int cn,
                                input logic bz);
        vec_t v;
        v.name = nm; v.act = act; v.rv = rv; v.down = dn; v.cks = ck; v.auto_r = au;
        v.tsr = ts; v.n = n; v.xs = {x4, x3, x2, x1, x0};
        v.ticks = tk; v.cnt = cn; v.busy = bz;
        return v;
    endfunction

    task automatic check_log(input string nm, input int n, input logic [4:0][16:0] xs);
        check({nm, " xfer count"}, log_q.size(), n);
        for (int i = 0; i < n; i++)
            if (i < log_q.size())
                check($sformatf("%s xfer%0d", nm, i), log_q[i], xs[i]);
    endtask

    vec_t vecs[15];

    initial begin
        vecs[0]  = mk("start_down", A_START, 8'hFF, 1, 2'b00, 1, 8'h00, 3,
                      xw(8'h00, 8'hFF), xw(8'h01, 8'hA0), xw(8'h01, 8'h30), 0, 0, 0, 0, 1);
        vecs[1]  = mk("irq_reload", A_IRQ, 8'h5A, 0, 2'b01, 0, 8'h02, 5,
                      xr(8'h02, 8'h02), xw(8'h02, 8'h00), xw(8'h00, 8'h5A),
                      xw(8'h01, 8'hA1), xw(8'h01, 8'h31), 1, 1, 1);
        vecs[2]  = mk("irq_noreload", A_IRQ, 8'h5A, 0, 2'b01, 0, 8'h02, 2,
                      xr(8'h02, 8'h02), xw(8'h02, 8'h00), 0, 0, 0, 1, 2, 1);
        vecs[3]  = mk("irq_wrong_flag", A_IRQ, 8'h5A, 0, 2'b01, 0, 8'h01, 1,
                      xr(8'h02, 8'h01), 0, 0, 0, 0, 0, 2, 1);
        vecs[4]  = mk("irq_spurious", A_IRQ, 8'h5A, 0, 2'b01, 0, 8'h00, 1,
                      xr(8'h02, 8'h00), 0, 0, 0, 0, 0, 2, 1);
        vecs[5]  = mk("stop_run", A_STOP, 8'h5A, 0, 2'b01, 0, 8'h00, 1,
                      xw(8'h01, 8'h21), 0, 0, 0, 0, 0, 2, 0);
        vecs[6]  = mk("irq_idle", A_IRQ, 8'h5A, 0, 2'b01, 0, 8'h02, 0,
                      0, 0, 0, 0, 0, 0, 2, 0);
        vecs[7]  = mk("start_up", A_START, 8'h10, 0, 2'b11, 0, 8'h00, 3,
                      xw(8'h00, 8'h10), xw(8'h01, 8'h83), xw(8'h01, 8'h13), 0, 0, 0, 2, 1);
        vecs[8]  = mk("irq_ovf", A_IRQ, 8'h10, 0, 2'b11, 0, 8'h01, 2,
                      xr(8'h02, 8'h01), xw(8'h02, 8'h00), 0, 0, 0, 1, 3, 1);
        vecs[9]  = mk("irq_unf_in_up", A_IRQ, 8'h10, 0, 2'b11, 0, 8'h02, 1,
                      xr(8'h02, 8'h02), 0, 0, 0, 0, 0, 3, 1);
        vecs[10] = mk("stop_up", A_STOP, 8'h10, 0, 2'b11, 0, 8'h00, 1,
                      xw(8'h01, 8'h03), 0, 0, 0, 0, 0, 3, 0);
        vecs[11] = mk("start_stop_idle", A_SS, 8'h10, 1, 2'b00, 0, 8'h00, 0,
                      0, 0, 0, 0, 0, 0, 3, 0);
        vecs[12] = mk("stop_idle", A_STOP, 8'h10, 1, 2'b00, 0, 8'h00, 0,
                      0, 0, 0, 0, 0, 0, 3, 0);
        vecs[13] = mk("restart", A_START, 8'hFF, 1, 2'b00, 0, 8'h00, 3,
                      xw(8'h00, 8'hFF), xw(8'h01, 8'hA0), xw(8'h01, 8'h30), 0, 0, 0, 3, 1);
        vecs[14] = mk("stop_restart", A_STOP, 8'hFF, 1, 2'b00, 0, 8'h00, 1,
                      xw(8'h01, 8'h20), 0, 0, 0, 0, 0, 3, 0);

        // reset state
        repeat (2) @(negedge pclk);
        check("reset apb", {m_psel, m_penable, m_pwrite, m_paddr, m_pwdata}, 0);
        check("reset busy", busy, 0);
        check("reset tick", tick, 0);
        check("reset period_cnt", period_cnt, 0);
        check("reset err", err, 0);
        presetn = 1;

        for (int r = 0; r < 15; r++) begin
            reload_val = vecs[r].rv; cfg_down = vecs[r].down; cfg_cks = vecs[r].cks;
            auto_reload = vecs[r].auto_r; tsr_val = vecs[r].tsr;
            log_q.delete(); tick_cnt = 0;
            pulse(vecs[r].act);
            repeat (40) @(negedge pclk);
            check_log(vecs[r].name, vecs[r].n, vecs[r].xs);
            check({vecs[r].name, " ticks"}, tick_cnt, vecs[r].ticks);
            check({vecs[r].name, " period_cnt"}, period_cnt, vecs[r].cnt);
            check({vecs[r].name, " busy"}, busy, vecs[r].busy);
            check({vecs[r].name, " err"}, err, 0);
            $display("vector %0d %s: %0d transfers", r, vecs[r].name, log_q.size());
        end

        // timeout: pready never arrives during WR_TDR
        slv_hang = 1; log_q.delete(); last_acc = 0;
        pulse(A_START);
        for (int k = 0; k < 100 && err !== 1'b1; k++) @(negedge pclk);
        @(negedge pclk);
        check("timeout err", err, 1);
        check("timeout access cycles", last_acc, 16);
        check("timeout apb idle", {m_psel, m_penable}, 0);
        check("timeout busy", busy, 0);
        slv_hang = 0;
        pulse(A_START);
        repeat (10) @(negedge pclk);
        check("start in error ignored", log_q.size(), 0);
        check("err sticky", err, 1);
        pulse_clr();
        check("err_clr", err, 0);
        check("err_clr busy", busy, 0);
        $display("sequence timeout: %0d access cycles", last_acc);

        // pready on the last allowed ACCESS cycle still completes
        slv_wait = 15; log_q.delete();
        pulse(A_START);
        repeat (90) @(negedge pclk);
        check("wait15 xfer count", log_q.size(), 3);
        check("wait15 err", err, 0);
        check("wait15 busy", busy, 1);
        pulse(A_STOP);
        repeat (40) @(negedge pclk);
        check("wait15 stopped", busy, 0);
        slv_wait = 0;
        $display("sequence wait15: done");

        // pslverr on WR_LOAD
        log_q.delete(); xfer_idx = 0; slv_err_idx = 1;
        pulse(A_START);
        repeat (30) @(negedge pclk);
        check("pslverr err", err, 1);
        check("pslverr xfer count", log_q.size(), 2);
        check("pslverr apb idle", {m_psel, m_penable}, 0);
        slv_err_idx = -1;
        pulse_clr();
        check("pslverr err_clr", err, 0);
        $display("sequence pslverr: done");

        // stop during WR_TDR waits for the transfer, then pauses
        reload_val = 8'h33; cfg_down = 1; cfg_cks = 2'b10; slv_wait = 3; log_q.delete();
        pulse(A_START);
        pulse(A_STOP);
        repeat (40) @(negedge pclk);
        check_log("stop_pending", 2, {17'd0, 17'd0, 17'd0, xw(8'h01, 8'h22), xw(8'h00, 8'h33)});
        check("stop_pending busy", busy, 0);
        slv_wait = 0;
        $display("sequence stop_pending: %0d transfers", log_q.size());

        // stop and irq in the same RUN cycle
        reload_val = 8'h44; cfg_cks = 2'b00;
        pulse(A_START);
        repeat (30) @(negedge pclk);
        log_q.delete(); tick_cnt = 0; tsr_val = 8'h02;
        pulse(A_IRQ_STOP);
        repeat (30) @(negedge pclk);
        check_log("stop_irq", 1, {17'd0, 17'd0, 17'd0, 17'd0, xw(8'h01, 8'h20)});
        check("stop_irq ticks", tick_cnt, 0);
        check("stop_irq busy", busy, 0);
        $display("sequence stop_irq: %0d transfers", log_q.size());

        // reset during ACCESS of WR_RUN
        reload_val = 8'h77; cfg_down = 1; cfg_cks = 2'b00; auto_reload = 0;
        slv_wait = 5; log_q.delete();
        pulse(A_START);
        for (int k = 0; k < 200 && !(log_q.size() == 2 && m_psel && m_penable); k++)
            @(negedge pclk);
        check("reached WR_RUN access", (log_q.size() == 2 && m_psel && m_penable), 1);
        #2 presetn = 0;
        #1;
        check("async reset apb", {m_psel, m_penable}, 0);
        check("async reset period_cnt", period_cnt, 0);
        check("async reset busy", busy, 0);
        repeat (2) @(negedge pclk);
        presetn = 1; slv_wait = 0; log_q.delete();
        pulse(A_START);
        repeat (30) @(negedge pclk);
        check_log("replay", 3, {17'd0, 17'd0, xw(8'h01, 8'h30), xw(8'h01, 8'hA0), xw(8'h00, 8'h77)});
        $display("sequence reset_replay: %0d transfers", log_q.size());

        // period_cnt wraps at 2^CW
        tsr_val = 8'h02; tick_cnt = 0;
        for (int k = 1; k <= 9; k++) begin
            pulse(A_IRQ);
            repeat (15) @(negedge pclk);
            check($sformatf("wrap period_cnt %0d", k), period_cnt, k % 8);
        end
        check("wrap ticks", tick_cnt, 9);
        $display("sequence wrap: period_cnt=%0d", period_cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_reload_ctrl.md
Name: timer_reload_ctrl

Overview:
APB master controller that programs and services the 8-bit timer (TDR 0x00, TCR 0x01, TSR 0x02) with no CPU involvement.
- On start it loads the reload value, selects the clock divider and direction, and enables counting.
- On each timer interrupt it reads TSR, acknowledges the overflow/underflow flag and optionally reloads.
- Emits one tick per timer period.
- Sits between the system control logic and the timer's APB slave port; a bus mux outside this block grants it the port.

Parameters:
ADDR_W, 8, APB address width
DATA_W, 8, APB data width
TIMEOUT, 16, max pclk cycles waiting for pready before error
CNT_W, 16, width of period counter

Ports:
pclk  in  1  clock (only clock)
presetn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin programming sequence
stop  in  1  one-cycle pulse: pause timer and return to idle
auto_reload  in  1  reload TDR after every period
reload_val  in  DATA_W  value written to TDR
cfg_down  in  1  1 = count down (underflow), 0 = count up (overflow)
cfg_cks  in  2  clock-select field for TCR[1:0]
err_clr  in  1  clears sticky err
irq_in  in  1  timer interrupt, level, high while a TSR flag is set
m_psel  out  1  APB select
m_penable  out  1  APB enable
m_pwrite  out  1  APB write
m_paddr  out  ADDR_W  APB address
m_pwdata  out  DATA_W  APB write data
m_prdata  in  DATA_W  APB read data
m_pready  in  1  APB ready
m_pslverr  in  1  APB slave error
busy  out  1  high in any state except IDLE and ERROR
tick  out  1  one-cycle pulse per serviced period
period_cnt  out  CNT_W  serviced periods, wraps
err  out  1  sticky bus error/timeout

Behaviour:
- Reset (async, presetn=0): every output is 0 and the FSM is in IDLE. Reset mid-transfer drops m_psel and m_penable immediately; no completion is required.
- TCR encoding: bit7 = load, bit5 = down, bit4 = enable, bits[1:0] = cks.
  - LOAD word = 0x80 | down<<5 | cks
  - RUN word = 0x10 | down<<5 | cks
  - PAUSE word = down<<5 | cks
- TSR flag: bit1 = underflow, bit0 = overflow. The expected flag is selected by cfg_down, which is sampled at start.
- APB transfer:
  - SETUP cycle: psel=1, penable=0.
  - ACCESS phase: psel=1, penable=1, held until pready=1.
  - Address, data and pwrite are stable across both phases. All outputs are 0 between transfers.
  - Minimum 2 cycles per transfer.
  - If pready does not arrive within TIMEOUT ACCESS cycles, or pslverr=1 with pready, go to ERROR.
- FSM:
  - IDLE: start -> WR_TDR.
  - WR_TDR: write reload_val to 0x00 -> WR_LOAD.
  - WR_LOAD: write LOAD word to 0x01 -> WR_RUN.
  - WR_RUN: write RUN word to 0x01 -> RUN.
  - RUN: irq_in=1 -> RD_TSR; stop -> WR_PAUSE.
  - RD_TSR: read 0x02. Expected flag set -> CLR_TSR. Otherwise (spurious) -> RUN, with no tick.
  - CLR_TSR: write 0x00 to 0x02. On completion, tick=1 for one cycle and period_cnt increments. Then go to WR_TDR if auto_reload=1, else RUN.
  - WR_PAUSE: write PAUSE word to 0x01 -> IDLE.
  - ERROR: err=1, APB idle, stays until err_clr -> IDLE. err_clr takes effect only in ERROR.
- stop outside RUN is latched as pending. It is acted on at the next transfer boundary: the current transfer finishes, then the FSM goes to WR_PAUSE.
- stop and irq_in in the same RUN cycle: stop wins, and TSR is left uncleared.
- start while busy or in ERROR is ignored. start and stop in the same IDLE cycle: stop wins, and the FSM stays in IDLE.
- reload_val, auto_reload and cfg_cks are sampled at each WR_TDR entry.
- period_cnt wraps from 2^CNT_W-1 to 0. It is cleared only by reset.

Decomposition:
- Package timer_pkg holds:
  - register addresses TDR_ADDR/TCR_ADDR/TSR_ADDR
  - TCR bit positions and TSR flag positions
  - FSM state enum
- Sub-module apb_master_xfer: one transfer per req pulse. It returns done, rdata and fail (pslverr or timeout), and owns the TIMEOUT counter.

Test Plan:
- Start with reload_val=0xFF, cfg_down=1, cks=2'b00 -> writes are 0x00←0xFF, 0x01←0xA0, 0x01←0x30, in that order; busy=1; then RUN with APB idle.
- Drive irq_in=1 with TSR read returning 0x02 -> write 0x02←0x00, tick pulses once, period_cnt=1; with auto_reload=1 the three-write sequence repeats.
- Drive irq_in with TSR returning 0x00 -> no TSR write, no tick, FSM back in RUN; period_cnt unchanged.
- Pulse stop in RUN -> write 0x01←0x20; then IDLE, busy=0; a later irq_in is ignored.
- Hold pready=0 for 16 ACCESS cycles during WR_TDR -> err=1, APB idle; err_clr -> IDLE, err=0. Also: pslverr=1 on WR_LOAD -> err=1.
- Assert presetn=0 during the ACCESS phase of WR_RUN -> m_psel/m_penable=0 at once, period_cnt=0, state IDLE; a new start replays the full sequence.
